// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR registers and single-word SRAM access sequencer.
// IDLE -> ACCESS (WAIT_STATES cycles of strobes) -> DONE (MEM_READY pulse) -> IDLE.
// Optional macro MEM_IO_MAP_EN maps address 16'hFFFF to SW (read) and HEX_OUT (write).
module mem_access_unit #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Bus,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    output logic        BUSY,
    output logic        MEM_READY,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    input  logic [9:0]  SW,
    output logic [15:0] HEX_OUT
);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_access_unit: WAIT_STATES must be in 1..15");
    end

    localparam logic [3:0] CntLoad = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;   // 1 = write
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        is_io;

`ifdef MEM_IO_MAP_EN
    logic [15:0] hex_q, hex_d;

    // MAR is frozen for the whole access, so this decode is stable and input-free.
    assign is_io   = (mar_q == 16'hFFFF);
    assign HEX_OUT = hex_q;

    // Display register, written by an I/O write at the ACCESS->DONE edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else begin
            hex_q <= hex_d;
        end
    end

    // Next value of the display register.
    always_comb begin
        hex_d = hex_q;
        if (state_q == StAccess && cnt_q == 4'd0 && dir_q && is_io) begin
            hex_d = mdr_q;
        end
    end
`else
    assign is_io   = 1'b0;
    assign HEX_OUT = '0;
`endif

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Next-state logic; register loads only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        unique case (state_q)
            StIdle: begin
                if (LD_MAR) mar_d = Bus;
                if (LD_MDR) mdr_d = Bus;
                if (MEM_REQ) begin
                    dir_d   = MEM_WE;
                    cnt_d   = CntLoad;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!dir_q) mdr_d = is_io ? {6'b0, SW} : Data_from_SRAM;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        BUSY         = (state_q != StIdle);
        MEM_READY    = (state_q == StDone);
        CE_N         = !(state_q == StAccess && !is_io);
        OE_N         = !(state_q == StAccess && !is_io && !dir_q);
        WE_N         = !(state_q == StAccess && !is_io && dir_q);
        MAR          = mar_q;
        MDR          = mdr_q;
        ADDR         = mar_q;
        Data_to_SRAM = mdr_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (WAIT_STATES = 2).
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Bus;
    logic        LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
    logic        BUSY, MEM_READY;
    logic [15:0] MAR, MDR, ADDR, Data_to_SRAM, Data_from_SRAM;
    logic        CE_N, OE_N, WE_N;
    logic [9:0]  SW;
    logic [15:0] HEX_OUT;

    int checks = 0;
    int errors = 0;
    int ce_low, oe_low, we_low, rdy_cnt, rdy_at;

    mem_access_unit #(.WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .BUSY(BUSY), .MEM_READY(MEM_READY),
        .MAR(MAR), .MDR(MDR), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
        .Data_from_SRAM(Data_from_SRAM), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
        .SW(SW), .HEX_OUT(HEX_OUT)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs applied before tick are sampled at that edge; outputs read 1 ns after.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sample n consecutive cycles starting with the current one, then advance.
    task automatic observe(input int n);
        ce_low = 0; oe_low = 0; we_low = 0; rdy_cnt = 0; rdy_at = -1;
        for (int i = 0; i < n; i++) begin
            if (!CE_N) ce_low++;
            if (!OE_N) oe_low++;
            if (!WE_N) we_low++;
            if (MEM_READY) begin
                rdy_cnt++;
                rdy_at = i;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Bus = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1;
        MEM_REQ = 1'b0; MEM_WE = 1'b0; Data_from_SRAM = 16'h0; SW = 10'h2A5;
        tick(); tick();
        chk("rst_mar", MAR, 16'h0);
        chk("rst_mdr", MDR, 16'h0);
        chk("rst_busy", 16'(BUSY), 16'h0);
        chk("rst_rdy", 16'(MEM_READY), 16'h0);
        chk("rst_strobes", {13'h0, CE_N, OE_N, WE_N}, 16'h0007);
        chk("rst_hex", HEX_OUT, 16'h0);

        // Reset pulse mid-idle with garbage on Bus/LD_MAR.
        Reset = 1'b0; LD_MDR = 1'b0; Bus = 16'h1111; tick();
        chk("idle_ld_mar", MAR, 16'h1111);
        Reset = 1'b1; Bus = 16'hABCD; tick();
        chk("rst_pulse_mar", MAR, 16'h0);
        Reset = 1'b0; LD_MAR = 1'b0;

        // Read of 0x3005 returning 0xBEEF.
        LD_MAR = 1'b1; Bus = 16'h3005; tick(); LD_MAR = 1'b0;
        chk("rd_addr", ADDR, 16'h3005);
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'hBEEF; tick(); MEM_REQ = 1'b0;
        chk("rd_busy", 16'(BUSY), 16'h1);
        observe(4);
        chk("rd_ce_cycles", 16'(ce_low), 16'd2);
        chk("rd_oe_cycles", 16'(oe_low), 16'd2);
        chk("rd_we_cycles", 16'(we_low), 16'd0);
        chk("rd_rdy_count", 16'(rdy_cnt), 16'd1);
        chk("rd_rdy_at", 16'(rdy_at), 16'd2);
        chk("rd_mdr", MDR, 16'hBEEF);
        chk("rd_busy_end", 16'(BUSY), 16'h0);

        // Write 0x1234 to 0x4000.
        LD_MAR = 1'b1; Bus = 16'h4000; tick(); LD_MAR = 1'b0;
        LD_MDR = 1'b1; Bus = 16'h1234; tick(); LD_MDR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b1; Data_from_SRAM = 16'h9999; tick(); MEM_REQ = 1'b0;
        chk("wr_data", Data_to_SRAM, 16'h1234);
        chk("wr_addr", ADDR, 16'h4000);
        observe(4);
        chk("wr_we_cycles", 16'(we_low), 16'd2);
        chk("wr_oe_cycles", 16'(oe_low), 16'd0);
        chk("wr_rdy_at", 16'(rdy_at), 16'd2);
        chk("wr_mdr_kept", MDR, 16'h1234);

        // Frozen registers during ACCESS; MEM_REQ held through DONE.
        LD_MAR = 1'b1; Bus = 16'h5000; tick(); LD_MAR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'h5555; tick();
        LD_MAR = 1'b1; LD_MDR = 1'b1; Bus = 16'h7777; tick();
        chk("frz_mar", MAR, 16'h5000);
        chk("frz_addr", ADDR, 16'h5000);
        chk("frz_mdr", MDR, 16'h1234);
        tick();
        LD_MAR = 1'b0; LD_MDR = 1'b0;
        chk("frz_done_rdy", 16'(MEM_READY), 16'h1);
        chk("frz_done_mdr", MDR, 16'h5555);
        tick();
        chk("frz_idle_busy", 16'(BUSY), 16'h0);
        tick(); MEM_REQ = 1'b0;
        chk("frz_second_ce", 16'(CE_N), 16'h0);
        tick(); tick(); tick();
        chk("frz_second_end", 16'(BUSY), 16'h0);

        // Reset in the first ACCESS cycle of a read.
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'hBEEF; tick(); MEM_REQ = 1'b0;
        chk("ra_ce_active", 16'(CE_N), 16'h0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("ra_strobes", {13'h0, CE_N, OE_N, WE_N}, 16'h0007);
        chk("ra_mdr", MDR, 16'h0);
        chk("ra_busy", 16'(BUSY), 16'h0);
        observe(4);
        chk("ra_no_rdy", 16'(rdy_cnt), 16'd0);
        chk("ra_mdr_after", MDR, 16'h0);

        // Address 0xFFFF: I/O when mapped, ordinary SRAM otherwise.
        LD_MAR = 1'b1; Bus = 16'hFFFF; tick(); LD_MAR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'hBEEF; tick(); MEM_REQ = 1'b0;
        observe(4);
        chk("io_rd_rdy_at", 16'(rdy_at), 16'd2);
`ifdef MEM_IO_MAP_EN
        chk("io_rd_ce", 16'(ce_low), 16'd0);
        chk("io_rd_mdr", MDR, 16'h02A5);
`else
        chk("io_rd_ce", 16'(ce_low), 16'd2);
        chk("io_rd_mdr", MDR, 16'hBEEF);
`endif
        LD_MDR = 1'b1; Bus = 16'h00C3; tick(); LD_MDR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b1; tick(); MEM_REQ = 1'b0;
        observe(4);
`ifdef MEM_IO_MAP_EN
        chk("io_wr_we", 16'(we_low), 16'd0);
        chk("io_wr_hex", HEX_OUT, 16'h00C3);
`else
        chk("io_wr_we", 16'(we_low), 16'd2);
        chk("io_wr_hex", HEX_OUT, 16'h0000);
`endif
        chk("io_wr_mdr", MDR, 16'h00C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
